// File: rtl/series_pkg.sv
// Shared constants and FSM state encoding for the series-accumulator bus driver.
package series_pkg;

    localparam int NIB_W           = 4;
    localparam int N_W             = 4;
    localparam int RES_W_DEF       = 16;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_N,
        S_SEND_X,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

endpackage

// File: rtl/series_bus_driver_nibble_serializer.sv
// Holds a latched x operand and presents it one nibble at a time, MSB first,
// with a flag marking the final nibble.
module nibble_serializer
    import series_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     shift,
    input  logic [NIB_W*NIBBLES-1:0] x_in,
    output logic [NIB_W-1:0]         nibble,
    output logic                     last
);

    localparam int X_W   = NIB_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [X_W-1:0]   sr;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples its inputs from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= x_in;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr << NIB_W;
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign nibble = sr[X_W-1 -: NIB_W];
    assign last   = (cnt == CNT_W'(NIBBLES - 1));

endmodule

// File: rtl/series_bus_driver.sv
// Initiator for the nibble-bus load protocol: serialises {n, x}, pulses start,
// waits for done and returns the result. Optional WAIT timeout: SERIES_TIMEOUT_EN.
module series_bus_driver
    import series_pkg::*;
#(
    parameter int X_NIBBLES   = 2,
    parameter int RES_W       = RES_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [NIB_W*X_NIBBLES-1:0] req_x,
    input  logic [N_W-1:0]             req_n,
    output logic [NIB_W-1:0]           in_bus,
    output logic                       n_reg_en,
    output logic                       x_reg_en,
    output logic                       start,
    input  logic                       done,
    input  logic [RES_W-1:0]           result,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [RES_W-1:0]           resp_data,
    output logic                       resp_err
);

    state_t           state, state_nx;
    logic [N_W-1:0]   n_q;
    logic [NIB_W-1:0] x_nibble;
    logic             x_last;
    logic             accept, shift, capture, timeout;

    nibble_serializer #(.NIBBLES(X_NIBBLES)) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (shift),
        .x_in   (req_x),
        .nibble (x_nibble),
        .last   (x_last)
    );

`ifdef SERIES_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_START)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;

            if (capture)                                err_q <= !done;
            else if (state == S_HOLD && resp_ready)     err_q <= 1'b0;
        end
    end

    assign timeout  = (state == S_WAIT) && (wait_cnt == 8'(TIMEOUT_CYC - 1));
    assign resp_err = err_q;
`else
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            n_q       <= '0;
            resp_data <= '0;
        end else begin
            state <= state_nx;
            if (accept)  n_q       <= req_n;
            // A timeout completes the response with an all-zero payload.
            if (capture) resp_data <= done ? result : '0;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        in_bus     = '0;
        n_reg_en   = 1'b0;
        x_reg_en   = 1'b0;
        start      = 1'b0;
        accept     = 1'b0;
        shift      = 1'b0;
        capture    = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = S_SEND_N;
                end
            end
            S_SEND_N: begin
                in_bus   = n_q;
                n_reg_en = 1'b1;
                state_nx = S_SEND_X;
            end
            S_SEND_X: begin
                in_bus   = x_nibble;
                x_reg_en = 1'b1;
                shift    = 1'b1;
                if (x_last) state_nx = S_START;
            end
            S_START: begin
                start    = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (done || timeout) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_series_bus_driver.sv
// Self-checking bench for series_bus_driver: directed protocol steps plus
// randomized transactions checked against a cycle-sequence reference model.
module tb_series_bus_driver;

    localparam int X_NIBBLES = 2;
    localparam int RES_W     = 16;
    localparam int TO_CYC    = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [7:0]       req_x = '0;
    logic [3:0]       req_n = '0;
    logic [3:0]       in_bus;
    logic             n_reg_en, x_reg_en, start;
    logic             done = 1'b0;
    logic [RES_W-1:0] result = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [RES_W-1:0] resp_data;
    logic             resp_err;

    int total = 0;
    int bad   = 0;

    series_bus_driver #(.X_NIBBLES(X_NIBBLES), .RES_W(RES_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_n      (req_n),
        .in_bus     (in_bus),
        .n_reg_en   (n_reg_en),
        .x_reg_en   (x_reg_en),
        .start      (start),
        .done       (done),
        .result     (result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected nibble i of x on the bus: most-significant nibble first.
    function automatic logic [3:0] exp_nib(input logic [7:0] x, input int i);
        return 4'((x >> (4 * (X_NIBBLES - 1 - i))) & 8'hF);
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_bus"}, 32'(in_bus), 32'h0);
        chk({tag, "_strb"}, {29'h0, n_reg_en, x_reg_en, start}, 32'h0);
        chk({tag, "_rv"}, 32'(resp_valid), 32'h0);
    endtask

    // One full request/response. keep_req raises the next request during HOLD.
    task automatic run_txn(input logic [7:0] x, input logic [3:0] n, input logic [15:0] r,
                           input int dly, input int stall, input bit spur,
                           input bit keep_req, input logic [7:0] nx, input logic [3:0] nn);
        req_x = x; req_n = n; req_valid = 1'b1;
        chk("idle_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = keep_req ? 1'b0 : 1'b0;
        req_x = 8'($urandom);
        req_n = 4'($urandom);
        if (spur) done = 1'b1;
        chk("sendn_bus", 32'(in_bus), 32'(n));
        chk("sendn_strb", {29'h0, n_reg_en, x_reg_en, start}, 32'b100);
        chk("sendn_req_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < X_NIBBLES; i++) begin
            tick();
            if (i == X_NIBBLES - 1) done = 1'b0;
            chk("sendx_bus", 32'(in_bus), 32'(exp_nib(x, i)));
            chk("sendx_strb", {29'h0, n_reg_en, x_reg_en, start}, 32'b010);
        end
        tick();
        chk("start_strb", {29'h0, n_reg_en, x_reg_en, start}, 32'b001);
        chk("start_bus", 32'(in_bus), 32'h0);
        tick();
        chk_idle_outputs("wait");
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("wait_rv", 32'(resp_valid), 32'h0);
        end
        done = 1'b1; result = r;
        tick();
        done = 1'b0; result = ~r;
        chk("hold_rv", 32'(resp_valid), 32'h1);
        chk("hold_data", 32'(resp_data), 32'(r));
        chk("hold_err", 32'(resp_err), 32'h0);
        if (keep_req) begin
            req_valid = 1'b1; req_x = nx; req_n = nn;
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_rv", 32'(resp_valid), 32'h1);
            chk("stall_data", 32'(resp_data), 32'(r));
            chk("stall_req_ready", 32'(req_ready), 32'h0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("post_rv", 32'(resp_valid), 32'h0);
        chk("post_req_ready", 32'(req_ready), 32'h1);
    endtask

    initial begin
        logic [7:0]  x;
        logic [3:0]  n, nn;
        logic [7:0]  nx;

        // Reset values
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk_idle_outputs("rst");
        chk("rst_data", 32'(resp_data), 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Directed load order and result hold with a 5-cycle stall
        run_txn(8'hA5, 4'h3, 16'h1234, 2, 5, 1'b0, 1'b0, 8'h00, 4'h0);

        // Spurious done during SEND_N/SEND_X, n = 0
        run_txn(8'h3C, 4'h0, 16'hBEEF, 0, 0, 1'b1, 1'b0, 8'h00, 4'h0);

        // Back-to-back: second request waits through HOLD
        run_txn(8'h5A, 4'h7, 16'hCAFE, 1, 3, 1'b0, 1'b1, 8'hF0, 4'hF);
        run_txn(8'hF0, 4'hF, 16'h0001, 3, 0, 1'b0, 1'b0, 8'h00, 4'h0);

        // Asynchronous reset mid-SEND_X abandons the transfer
        req_x = 8'h96; req_n = 4'h9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_xen", 32'(x_reg_en), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk_idle_outputs("mid_rst");
        chk("mid_rst_req_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_err", 32'(resp_err), 32'h0);
        done = 1'b1;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("after_rst_rv", 32'(resp_valid), 32'h0);
        chk("after_rst_req_ready", 32'(req_ready), 32'h1);
        chk("after_rst_bus", 32'(in_bus), 32'h0);
        done = 1'b0;
        tick();

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            x  = 8'($urandom);
            n  = 4'($urandom);
            nx = 8'($urandom);
            nn = 4'($urandom);
            run_txn(x, n, 16'($urandom), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 4)), 1'($urandom), 1'b0, nx, nn);
        end

        // Missing done: timeout response, or unbounded wait when compiled out
        req_x = 8'h77; req_n = 4'h2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < X_NIBBLES + 2; i++) tick();
`ifdef SERIES_TIMEOUT_EN
        for (int i = 0; i < TO_CYC - 1; i++) tick();
        chk("to_before_rv", 32'(resp_valid), 32'h0);
        tick();
        chk("to_rv", 32'(resp_valid), 32'h1);
        chk("to_err", 32'(resp_err), 32'h1);
        chk("to_data", 32'(resp_data), 32'h0);
`else
        for (int i = 0; i < TO_CYC + 40; i++) tick();
        chk("nto_rv", 32'(resp_valid), 32'h0);
        chk("nto_err", 32'(resp_err), 32'h0);
        done = 1'b1; result = 16'h5555;
        tick();
        done = 1'b0;
        chk("nto_rv_late", 32'(resp_valid), 32'h1);
        chk("nto_data", 32'(resp_data), 32'h5555);
`endif
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("final_rv", 32'(resp_valid), 32'h0);
        chk("final_err", 32'(resp_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
